mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the 3-stage Riscv151 core.
- Accepts one line request at a time, arbitrates with data-cache priority plus an instruction-starvation bound, and sequences a fixed-length multi-beat burst.
- Routes read beats back to the owning cache and passes writeback beats through to memory.
- Sits between the caches and the memory model, below the `stall` generation logic.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/arb_starve_pick.sv | 56 +++++
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the main-memory arbiter that sits between the
// I-cache / D-cache refill paths and the single memory port.
//   - FSM state encoding (IDLE/ISSUE/READ/WRITE)
//   - burst owner encoding (IC/DC)
//   - line_off_mask(): byte-offset mask of one cache line, used to align the
//     latched request address to the start of its line
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  // A line is beats * (data_w / 8) bytes. Both factors are powers of two, so
  // the byte-offset mask is simply the line size minus one.
  function automatic logic [63:0] line_off_mask(input int beats, input int data_w);
    return 64'(beats * (data_w / 8) - 1);
  endfunction

endpackage

// File: rtl/arb_starve_pick.sv
// -----------------------------------------------------------------------------
// arb_starve_pick
// Grant decision for the memory arbiter: the D-cache wins ties, but after
// MAX_DWIN consecutive D-cache wins with an I-cache request waiting, the
// I-cache gets the next grant. Kept separate so the fairness policy can be
// replaced without touching the burst sequencer.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   grant_en_i    arbiter is able to grant this cycle
//   ic_valid_i    I-cache request pending
//   dc_valid_i    D-cache request pending
//   grant_ic_o    I-cache granted this cycle
//   grant_dc_o    D-cache granted this cycle
// -----------------------------------------------------------------------------
module arb_starve_pick #(
  parameter int MAX_DWIN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_en_i,
  input  logic ic_valid_i,
  input  logic dc_valid_i,
  output logic grant_ic_o,
  output logic grant_dc_o
);

  localparam int CNT_W = (MAX_DWIN < 1) ? 1 : $clog2(MAX_DWIN + 1);
  localparam logic [CNT_W-1:0] DWIN_MAX = CNT_W'(MAX_DWIN);

  // Consecutive D-cache grants made while the I-cache was kept waiting.
  logic [CNT_W-1:0] dwin_q, dwin_d;

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path (defaults
    // first), so the block stays purely combinational with no latches.
    grant_ic_o = grant_en_i && ic_valid_i && (!dc_valid_i || dwin_q == DWIN_MAX);
    grant_dc_o = grant_en_i && dc_valid_i && !grant_ic_o;
    dwin_d     = dwin_q;
    if (grant_dc_o) begin
      // Only a win that actually made the I-cache wait counts toward the bound.
      if (!ic_valid_i)            dwin_d = '0;
      else if (dwin_q != DWIN_MAX) dwin_d = dwin_q + CNT_W'(1);
    end else if (grant_ic_o) begin
      dwin_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwin_q <= '0;
    else        dwin_q <= dwin_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single main-memory port between the I-cache refill path and the
// D-cache refill/writeback path. One line request is accepted at a time; the
// line is moved as a fixed BEATS-long burst.
//
// Ports
//   clk, reset_n                          clock, asynchronous active-low reset
//   ic_req_valid/ready/addr               I-cache line read request
//   ic_resp_valid/data/last               I-cache read beats
//   dc_req_valid/ready/addr/we            D-cache request (we=1: writeback)
//   dc_wdata_valid/ready/dc_wdata         D-cache writeback beats
//   dc_resp_valid/data/last               D-cache read beats
//   mem_req_valid/ready/addr/we           memory command
//   mem_wdata_valid/ready/mem_wdata       memory write beats
//   mem_resp_valid/data                   memory read beats (in order, no
//                                         backpressure)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BEATS    = 4,
  parameter int MAX_DWIN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // I-cache request / response
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  output logic              ic_resp_last,
  // D-cache request / writeback / response
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_we,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              dc_resp_last,
  // Memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int                BEAT_W    = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(line_off_mask(BEATS, DATA_W));

  logic [1:0]        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              we_q,    we_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  // Set for the single IDLE cycle that follows a burst; no grant is made then.
  logic              cool_q,  cool_d;

  logic grant_en, grant_ic, grant_dc;
  logic beat_last, rd_beat, wr_active, wr_beat;

  // Gating with reset_n keeps the grant outputs low while reset is held,
  // even though the state flops already read IDLE.
  assign grant_en = reset_n && (state_q == ST_IDLE) && !cool_q;

  arb_starve_pick #(
    .MAX_DWIN (MAX_DWIN)
  ) u_pick (
    .clk        (clk),
    .rst_n      (reset_n),
    .grant_en_i (grant_en),
    .ic_valid_i (ic_req_valid),
    .dc_valid_i (dc_req_valid),
    .grant_ic_o (grant_ic),
    .grant_dc_o (grant_dc)
  );

  // ---------------------------------------------------------------- outputs
  always_comb begin
    ic_req_ready  = grant_ic;
    dc_req_ready  = grant_dc;

    mem_req_valid = (state_q == ST_ISSUE);
    mem_req_addr  = addr_q;
    mem_req_we    = we_q;

    beat_last     = (beat_q == BEAT_LAST);

    // Read beats go straight from memory to the owning cache.
    rd_beat       = (state_q == ST_READ) && mem_resp_valid;
    ic_resp_valid = rd_beat && (owner_q == OWN_IC);
    dc_resp_valid = rd_beat && (owner_q == OWN_DC);
    ic_resp_data  = ic_resp_valid ? mem_resp_data : '0;
    dc_resp_data  = dc_resp_valid ? mem_resp_data : '0;
    ic_resp_last  = ic_resp_valid && beat_last;
    dc_resp_last  = dc_resp_valid && beat_last;

    // Writeback beats pass through combinationally while in WRITE only.
    wr_active       = (state_q == ST_WRITE);
    mem_wdata_valid = wr_active && dc_wdata_valid;
    dc_wdata_ready  = wr_active && mem_wdata_ready;
    mem_wdata       = wr_active ? dc_wdata : '0;
    wr_beat         = mem_wdata_valid && mem_wdata_ready;
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_q_hold: begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      we_d    = we_q;
      beat_d  = beat_q;
      cool_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_ic) begin
          state_d = ST_ISSUE;
          owner_d = OWN_IC;
          addr_d  = ic_req_addr & ~LINE_MASK;
          we_d    = 1'b0;
        end else if (grant_dc) begin
          state_d = ST_ISSUE;
          owner_d = OWN_DC;
          addr_d  = dc_req_addr & ~LINE_MASK;
          we_d    = dc_req_we;
        end
      end

      ST_ISSUE: begin
        if (mem_req_ready) begin
          state_d = we_q ? ST_WRITE : ST_READ;
          beat_d  = '0;
        end
      end

      ST_READ: begin
        if (rd_beat) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_last) begin
            state_d = ST_IDLE;
            cool_d  = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (wr_beat) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_last) begin
            state_d = ST_IDLE;
            cool_d  = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IC;
      addr_q  <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      cool_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      cool_q  <= cool_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising (active) edge.
// Expected grant order comes from the priority/starvation rule evaluated with
// plain integers; expected data/addresses come from bench-generated values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BEATS      = 4;
  localparam int MAX_DWIN   = 4;
  localparam int LINE_BYTES = BEATS * DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ic_req_valid, ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid, ic_resp_last;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid, dc_req_ready, dc_req_we;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_wdata_valid, dc_wdata_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_resp_valid, dc_resp_last;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wdata_valid, mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_data [BEATS];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .MAX_DWIN(MAX_DWIN)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we),
    .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready), .dc_wdata(dc_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_last(dc_resp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------- drive helpers
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_we = 0;
    dc_wdata_valid = 0; dc_wdata = '0;
    mem_req_ready = 0; mem_wdata_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic fill_data();
    for (int i = 0; i < BEATS; i++) exp_data[i] = $urandom;
  endtask

  // Raises one requester and waits (bounded) for its grant; returns at the
  // falling edge of the ISSUE cycle with the request dropped.
  task automatic grant_one(input string tag, input bit dc, input logic [ADDR_W-1:0] a,
                           input logic we);
    bit got;
    got = 0;
    if (dc) begin dc_req_valid = 1; dc_req_addr = a; dc_req_we = we; end
    else    begin ic_req_valid = 1; ic_req_addr = a; end
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (ic_req_ready || dc_req_ready) begin
        got = 1;
        checks++;
        if ({ic_req_ready, dc_req_ready, mem_req_valid} !== {!dc, dc, 1'b0}) begin
          errors++;
          $display("FAIL %s grant: got ic=%0b dc=%0b mreq=%0b, want ic=%0b dc=%0b mreq=0",
                   tag, ic_req_ready, dc_req_ready, mem_req_valid, !dc, dc);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s grant_timeout: got no ready, want ready within 10 cycles", tag);
    end
    if (dc) dc_req_valid = 0; else ic_req_valid = 0;
  endtask

  // Called in the ISSUE cycle: holds mem_req_ready low for 'hold' cycles, then
  // accepts. Returns at the falling edge of the first data cycle.
  task automatic serve_cmd(input string tag, input int hold, input logic [ADDR_W-1:0] ea,
                           input logic ewe);
    for (int i = 0; i <= hold; i++) begin
      mem_req_ready = (i == hold);
      #1;
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_we} !== {1'b1, ea, ewe}) begin
        errors++;
        $display("FAIL %s cmd[%0d]: got v=%0b a=%h we=%0b, want v=1 a=%h we=%0b",
                 tag, i, mem_req_valid, mem_req_addr, mem_req_we, ea, ewe);
      end
      checks++;
      if ({ic_req_ready, dc_req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL %s cmd_regrant[%0d]: got ic=%0b dc=%0b, want 0 0",
                 tag, i, ic_req_ready, dc_req_ready);
      end
      @(negedge clk);
    end
    mem_req_ready = 0;
  endtask

  // Plays the memory side of a read burst with random gaps; returns at the
  // falling edge of the first grant-eligible cycle after the burst.
  task automatic serve_read(input string tag, input bit dc_owner, input int max_gap);
    int gap;
    logic v, l, other;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < BEATS; i++) begin
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        mem_resp_valid = 0;
        #1;
        checks++;
        if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
          errors++;
          $display("FAIL %s rd_gap: got icv=%0b dcv=%0b, want 0 0", tag, ic_resp_valid, dc_resp_valid);
        end
        @(negedge clk);
      end
      mem_resp_valid = 1;
      mem_resp_data  = exp_data[i];
      #1;
      v     = dc_owner ? dc_resp_valid : ic_resp_valid;
      d     = dc_owner ? dc_resp_data  : ic_resp_data;
      l     = dc_owner ? dc_resp_last  : ic_resp_last;
      other = dc_owner ? ic_resp_valid : dc_resp_valid;
      checks++;
      if ({v, d, l, other} !== {1'b1, exp_data[i], (i == BEATS - 1), 1'b0}) begin
        errors++;
        $display("FAIL %s rd_beat%0d: got v=%0b d=%h last=%0b other=%0b, want v=1 d=%h last=%0b other=0",
                 tag, i, v, d, l, other, exp_data[i], (i == BEATS - 1));
      end
      @(negedge clk);
    end
    // First IDLE cycle: a stray beat is ignored and no grant is allowed yet.
    mem_resp_valid = 1;
    #1;
    checks++;
    if ({ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL %s rd_after: got icv=%0b dcv=%0b icr=%0b dcr=%0b, want all 0",
               tag, ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready);
    end
    mem_resp_valid = 0;
    mem_resp_data  = '0;
    @(negedge clk);
  endtask

  // Plays both ends of a writeback burst. mode 0: no stalls, 1: memory ready
  // low on alternate cycles, 2: random stalls on both sides.
  task automatic serve_write(input string tag, input int mode);
    int k, n;
    logic rdy, vld;
    k = 0;
    n = 0;
    while (k < BEATS && n < 40) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : 1'($urandom_range(0, 1));
      vld = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_wdata_ready = rdy;
      dc_wdata_valid  = vld;
      dc_wdata        = vld ? exp_data[k] : 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({dc_wdata_ready, mem_wdata_valid} !== {rdy, vld}) begin
        errors++;
        $display("FAIL %s wr_pass%0d: got dcrdy=%0b mvld=%0b, want dcrdy=%0b mvld=%0b",
                 tag, n, dc_wdata_ready, mem_wdata_valid, rdy, vld);
      end
      if (vld && rdy) begin
        checks++;
        if (mem_wdata !== exp_data[k]) begin
          errors++;
          $display("FAIL %s wr_beat%0d: got %h, want %h", tag, k, mem_wdata, exp_data[k]);
        end
        k++;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (k != BEATS) begin
      errors++;
      $display("FAIL %s wr_timeout: got %0d beats, want %0d", tag, k, BEATS);
    end
    // Back in IDLE: a further writeback beat is refused.
    dc_wdata_valid  = 1;
    mem_wdata_ready = 1;
    #1;
    checks++;
    if ({dc_wdata_ready, mem_wdata_valid, ic_req_ready, dc_req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL %s wr_after: got dcrdy=%0b mvld=%0b icr=%0b dcr=%0b, want all 0",
               tag, dc_wdata_ready, mem_wdata_valid, ic_req_ready, dc_req_ready);
    end
    dc_wdata_valid  = 0;
    mem_wdata_ready = 0;
    @(negedge clk);
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    ic_req_valid = 1; dc_req_valid = 1; dc_wdata_valid = 1;
    mem_req_ready = 1; mem_wdata_ready = 1; mem_resp_valid = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({ic_req_ready, dc_req_ready, dc_wdata_ready, mem_req_valid, mem_wdata_valid,
         ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last, mem_req_we} !== 10'b0 ||
        mem_req_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b%0b%0b v=%0b%0b%0b%0b last=%0b%0b we=%0b a=%h, want all 0",
               ic_req_ready, dc_req_ready, dc_wdata_ready, mem_req_valid, mem_wdata_valid,
               ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last, mem_req_we, mem_req_addr);
    end
    @(negedge clk);
    clear_inputs();
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_ic_read();
    fill_data();
    grant_one("ic_read", 0, 32'h0000_1234, 1'b0);
    serve_cmd("ic_read", 0, 32'h0000_1230, 1'b0);
    serve_read("ic_read", 0, 0);
  endtask

  task automatic test_dc_write_stall();
    fill_data();
    grant_one("dc_wr", 1, 32'h0000_0100, 1'b1);
    serve_cmd("dc_wr", 0, 32'h0000_0100, 1'b1);
    serve_write("dc_wr", 1);
  endtask

  task automatic test_starvation();
    bit got, want_ic;
    do_reset();
    ic_req_valid = 1; ic_req_addr = 32'h0000_2004;
    dc_req_valid = 1; dc_req_addr = 32'h0000_3008; dc_req_we = 0;
    for (int n = 0; n < 10; n++) begin
      want_ic = (n % 5 == 4);
      got = 0;
      for (int w = 0; w < 5 && !got; w++) begin
        #1;
        if (ic_req_ready || dc_req_ready) got = 1;
        else @(negedge clk);
      end
      checks++;
      if ({got, ic_req_ready, dc_req_ready} !== {1'b1, want_ic, !want_ic}) begin
        errors++;
        $display("FAIL starve_grant%0d: got granted=%0b ic=%0b dc=%0b, want granted=1 ic=%0b dc=%0b",
                 n, got, ic_req_ready, dc_req_ready, want_ic, !want_ic);
      end
      if (!got) break;
      @(negedge clk);
      fill_data();
      serve_cmd("starve", 0, want_ic ? 32'h0000_2000 : 32'h0000_3000, 1'b0);
      serve_read("starve", !want_ic, 0);
    end
    ic_req_valid = 0;
    dc_req_valid = 0;
  endtask

  task automatic test_spurious();
    mem_resp_valid = 1;
    mem_resp_data  = 32'hBAD0_0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL spur_idle%0d: got icv=%0b dcv=%0b, want 0 0", i, ic_resp_valid, dc_resp_valid);
      end
      @(negedge clk);
    end
    mem_resp_valid = 0;
    fill_data();
    grant_one("spur", 0, 32'h0000_7778, 1'b0);
    mem_resp_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL spur_issue%0d: got icv=%0b dcv=%0b, want 0 0", i, ic_resp_valid, dc_resp_valid);
      end
      @(negedge clk);
    end
    mem_resp_valid = 0;
    // last must still land on the fourth real beat
    serve_cmd("spur", 0, 32'h0000_7770, 1'b0);
    serve_read("spur", 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    fill_data();
    grant_one("rst_mid", 0, 32'h0000_4000, 1'b0);
    serve_cmd("rst_mid", 0, 32'h0000_4000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1;
      mem_resp_data  = exp_data[i];
      @(negedge clk);
    end
    reset_n = 0;
    ic_req_valid = 1; dc_req_valid = 1; dc_wdata_valid = 1;
    mem_req_ready = 1; mem_wdata_ready = 1;
    #1;
    checks++;
    if ({ic_req_ready, dc_req_ready, dc_wdata_ready, mem_req_valid, mem_wdata_valid,
         ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last, mem_req_we} !== 10'b0 ||
        mem_req_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got rdy=%0b%0b%0b v=%0b%0b%0b%0b last=%0b%0b we=%0b a=%h, want all 0",
               ic_req_ready, dc_req_ready, dc_wdata_ready, mem_req_valid, mem_wdata_valid,
               ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last, mem_req_we, mem_req_addr);
    end
    @(negedge clk);
    clear_inputs();
    reset_n = 1;
    @(negedge clk);
    fill_data();
    grant_one("rst_after", 1, 32'h0000_500C, 1'b0);
    serve_cmd("rst_after", 0, 32'h0000_5000, 1'b0);
    serve_read("rst_after", 1, 1);
  endtask

  task automatic test_held_ready();
    fill_data();
    grant_one("held", 1, 32'h0000_0604, 1'b0);
    ic_req_valid = 1;
    ic_req_addr  = 32'h0000_0A0F;
    serve_cmd("held", 5, 32'h0000_0600, 1'b0);
    serve_read("held", 1, 0);
    // The waiting I-cache request is granted on the first eligible cycle.
    #1;
    checks++;
    if ({ic_req_ready, dc_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL held_next_grant: got ic=%0b dc=%0b, want ic=1 dc=0", ic_req_ready, dc_req_ready);
    end
    @(negedge clk);
    ic_req_valid = 0;
    fill_data();
    serve_cmd("held_ic", 0, 32'h0000_0A00, 1'b0);
    serve_read("held_ic", 0, 0);
  endtask

  task automatic test_random();
    bit pend_ic, pend_dc, win_dc, dc_w;
    logic [ADDR_W-1:0] ic_a, dc_a, ea;
    logic ewe;
    int dwin;
    do_reset();
    pend_ic = 0; pend_dc = 0; dwin = 0;
    ic_a = '0; dc_a = '0; dc_w = 0;
    for (int n = 0; n < 40; n++) begin
      if (!pend_ic && $urandom_range(0, 1) == 1) begin
        pend_ic = 1; ic_a = $urandom;
      end
      if (!pend_dc && ($urandom_range(0, 1) == 1 || !pend_ic)) begin
        pend_dc = 1; dc_a = $urandom; dc_w = 1'($urandom_range(0, 1));
      end
      ic_req_valid = pend_ic; ic_req_addr = ic_a;
      dc_req_valid = pend_dc; dc_req_addr = dc_a; dc_req_we = dc_w;
      #1;
      // D-cache wins unless it has already won MAX_DWIN times over a waiting I-cache.
      win_dc = pend_dc && !(pend_ic && dwin == MAX_DWIN);
      checks++;
      if ({ic_req_ready, dc_req_ready} !== {!win_dc, win_dc}) begin
        errors++;
        $display("FAIL rand_grant%0d: got ic=%0b dc=%0b, want ic=%0b dc=%0b (pend ic=%0b dc=%0b dwin=%0d)",
                 n, ic_req_ready, dc_req_ready, !win_dc, win_dc, pend_ic, pend_dc, dwin);
      end
      if (win_dc) dwin = pend_ic ? ((dwin < MAX_DWIN) ? dwin + 1 : dwin) : 0;
      else        dwin = 0;
      ea  = line_base(win_dc ? dc_a : ic_a);
      ewe = win_dc ? dc_w : 1'b0;
      if (win_dc) pend_dc = 0; else pend_ic = 0;
      @(negedge clk);
      ic_req_valid = pend_ic;
      dc_req_valid = pend_dc;
      fill_data();
      serve_cmd("rand", $urandom_range(0, 3), ea, ewe);
      if (ewe) serve_write("rand", 2);
      else     serve_read("rand", win_dc, 2);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    test_reset();
    test_ic_read();
    test_dc_write_stall();
    test_spurious();
    test_held_ready();
    test_reset_mid_burst();
    test_starvation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
